flow_step_controller: RTL and testbench

Execution sequencer for the `flow` core, sitting between the board push-buttons and the core's clock-enable input. It debounces raw step/run keys and runs a five-state FSM: halted, single-step, free-run, breakpoint, resume. From that FSM it generates a per-cycle core enable, which is gated by a PC breakpoint comparator, a lock input and a core halt request. It also keeps a 16-bit count of executed cycles for display on the hex/debug path.

---
 rtl/flow_step_controller.sv | 133 +++++++++++++
 tb/tb_flow_step_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/flow_step_controller.sv
// Run/step sequencer for the flow core: debounced keys drive a five-state FSM
// that gates the core clock-enable, with a PC breakpoint and a wrapping executed-cycle count.

module flow_step_key #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1, s, stable, stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1    <= 1'b0;
            s        <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            s        <= sync1;
            stable_q <= stable;
            // Any return of s to the accepted level restarts the stability window.
            if (s != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= s;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = stable & ~stable_q;
endmodule

module flow_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PC_WIDTH        = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                step_key,
    input  logic                run_key,
    input  logic                clock_lock,
    input  logic                halt_request,
    input  logic                break_enable,
    input  logic [PC_WIDTH-1:0] break_addr,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                core_enable,
    output logic                running,
    output logic                break_hit,
    output logic [2:0]          state,
    output logic [15:0]         step_count
);
    typedef enum logic [2:0] {
        HALTED = 3'd0,
        STEP   = 3'd1,
        RUN    = 3'd2,
        BREAK  = 3'd3,
        RESUME = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   step_press, run_press, bp;

    flow_step_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clock (clock),
        .resetn(resetn),
        .raw   (step_key),
        .press (step_press)
    );

    flow_step_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clock (clock),
        .resetn(resetn),
        .raw   (run_key),
        .press (run_press)
    );

    assign bp = break_enable & (pc == break_addr);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= HALTED;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clock_lock) begin
            state_d = HALTED;
        end else if (halt_request && (state_q == STEP || state_q == RUN || state_q == RESUME)) begin
            state_d = HALTED;
        end else if (state_q == RUN && bp) begin
            state_d = BREAK;
        end else begin
            case (state_q)
                HALTED: begin
                    if (step_press)     state_d = STEP;
                    else if (run_press) state_d = RUN;
                end
                RUN:    if (run_press) state_d = HALTED;
                BREAK: begin
                    if (step_press)     state_d = STEP;
                    else if (run_press) state_d = RESUME;
                end
                STEP:    state_d = HALTED;
                RESUME:  state_d = RUN;
                default: state_d = HALTED;
            endcase
        end
    end

    // STEP and RESUME ignore bp so a resumed core moves off the breakpoint PC.
    assign core_enable = ~clock_lock & ~halt_request &
                         ((state_q == STEP) | (state_q == RESUME) | ((state_q == RUN) & ~bp));
    assign running     = (state_q == RUN) | (state_q == RESUME);
    assign break_hit   = (state_q == BREAK);
    assign state       = state_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)          step_count <= '0;
        else if (core_enable) step_count <= step_count + 16'd1;
    end
endmodule

// File: tb/tb_flow_step_controller.sv
// Directed bench for flow_step_controller (DEBOUNCE_CYCLES=4): key latency, bounce,
// run/stop, breakpoint, priorities, counter wrap and async reset.

module tb_flow_step_controller;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        step_key = 1'b0, run_key = 1'b0, clock_lock = 1'b0;
    logic        halt_request = 1'b0, break_enable = 1'b0;
    logic [15:0] break_addr = 16'h0010;
    logic [15:0] pc;
    logic        core_enable, running, break_hit;
    logic [2:0]  state;
    logic [15:0] step_count;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    assign pc = step_count;

    flow_step_controller #(.DEBOUNCE_CYCLES(4), .PC_WIDTH(16)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .step_key    (step_key),
        .run_key     (run_key),
        .clock_lock  (clock_lock),
        .halt_request(halt_request),
        .break_enable(break_enable),
        .break_addr  (break_addr),
        .pc          (pc),
        .core_enable (core_enable),
        .running     (running),
        .break_hit   (break_hit),
        .state       (state),
        .step_count  (step_count)
    );

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0; step_key = 1'b0; run_key = 1'b0; clock_lock = 1'b0;
        halt_request = 1'b0; break_enable = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetn = 1'b0;
        #1;
        total++; if (state !== 3'd0) $display("FAIL reset_state got %0d exp 0", state); else passed++;
        total++; if (core_enable !== 1'b0) $display("FAIL reset_ce got %b exp 0", core_enable); else passed++;
        total++; if (running !== 1'b0) $display("FAIL reset_running got %b exp 0", running); else passed++;
        total++; if (break_hit !== 1'b0) $display("FAIL reset_break_hit got %b exp 0", break_hit); else passed++;
        total++; if (step_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", step_count); else passed++;
        do_reset();
    endtask

    task automatic test_single_step();
        int ce_cnt = 0, ce_at = -1;
        logic [2:0] st7 = 3'd0;
        do_reset();
        step_key = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (core_enable === 1'b1) begin ce_cnt++; ce_at = k; end
            if (k == 7) st7 = state;
        end
        step_key = 1'b0;
        repeat (12) @(negedge clock);
        total++; if (ce_cnt != 1) $display("FAIL step_ce_count got %0d exp 1", ce_cnt); else passed++;
        total++; if (ce_at != 7) $display("FAIL step_ce_edge got %0d exp 7", ce_at); else passed++;
        total++; if (st7 !== 3'd1) $display("FAIL step_state7 got %0d exp 1", st7); else passed++;
        total++; if (step_count !== 16'd1) $display("FAIL step_count got %0d exp 1", step_count); else passed++;
        total++; if (state !== 3'd0) $display("FAIL step_final_state got %0d exp 0", state); else passed++;
    endtask

    task automatic test_bounce();
        int ce_cnt = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step_key = 1'b1;
            repeat (2) begin @(negedge clock); if (core_enable === 1'b1) ce_cnt++; end
            step_key = 1'b0;
            repeat (2) begin @(negedge clock); if (core_enable === 1'b1) ce_cnt++; end
        end
        repeat (10) begin @(negedge clock); if (core_enable === 1'b1) ce_cnt++; end
        total++; if (ce_cnt != 0) $display("FAIL bounce_ce got %0d exp 0", ce_cnt); else passed++;
        total++; if (step_count !== 16'd0) $display("FAIL bounce_count got %0d exp 0", step_count); else passed++;
        total++; if (state !== 3'd0) $display("FAIL bounce_state got %0d exp 0", state); else passed++;
    endtask

    task automatic test_run_stop();
        int ce_cnt = 0;
        do_reset();
        run_key = 1'b1;
        repeat (7) @(negedge clock);
        total++; if (state !== 3'd2) $display("FAIL run_state got %0d exp 2", state); else passed++;
        total++; if (running !== 1'b1) $display("FAIL run_running got %b exp 1", running); else passed++;
        run_key = 1'b0;
        // Samples k=7..56 are all enabled; count reaches 50 at k=57.
        for (int k = 7; k < 57; k++) begin
            if (core_enable === 1'b1) ce_cnt++;
            @(negedge clock);
        end
        total++; if (ce_cnt != 50) $display("FAIL run_ce_cycles got %0d exp 50", ce_cnt); else passed++;
        total++; if (step_count !== 16'd50) $display("FAIL run_count50 got %0d exp 50", step_count); else passed++;
        run_key = 1'b1;
        repeat (6) @(negedge clock);
        total++; if (state !== 3'd2) $display("FAIL stop_state_pre got %0d exp 2", state); else passed++;
        @(negedge clock);
        total++; if (state !== 3'd0) $display("FAIL stop_state got %0d exp 0", state); else passed++;
        total++; if (step_count !== 16'd57) $display("FAIL stop_count got %0d exp 57", step_count); else passed++;
        total++; if (core_enable !== 1'b0) $display("FAIL stop_ce got %b exp 0", core_enable); else passed++;
        run_key = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_breakpoint();
        do_reset();
        break_enable = 1'b1;
        break_addr   = 16'h0010;
        run_key = 1'b1;
        repeat (7) @(negedge clock);
        run_key = 1'b0;
        repeat (16) @(negedge clock);
        total++; if (pc !== 16'h0010) $display("FAIL bp_pc got %h exp 0010", pc); else passed++;
        total++; if (core_enable !== 1'b0) $display("FAIL bp_ce_drop got %b exp 0", core_enable); else passed++;
        total++; if (state !== 3'd2) $display("FAIL bp_state_run got %0d exp 2", state); else passed++;
        @(negedge clock);
        total++; if (state !== 3'd3) $display("FAIL bp_state got %0d exp 3", state); else passed++;
        total++; if (break_hit !== 1'b1) $display("FAIL bp_hit got %b exp 1", break_hit); else passed++;
        total++; if (step_count !== 16'h0010) $display("FAIL bp_count got %0d exp 16", step_count); else passed++;
        run_key = 1'b1;
        repeat (7) @(negedge clock);
        total++; if (state !== 3'd4) $display("FAIL resume_state got %0d exp 4", state); else passed++;
        total++; if (core_enable !== 1'b1) $display("FAIL resume_ce got %b exp 1", core_enable); else passed++;
        total++; if (running !== 1'b1) $display("FAIL resume_running got %b exp 1", running); else passed++;
        @(negedge clock);
        total++; if (state !== 3'd2) $display("FAIL resume_to_run got %0d exp 2", state); else passed++;
        total++; if (pc !== 16'h0011) $display("FAIL resume_pc got %h exp 0011", pc); else passed++;
        total++; if (core_enable !== 1'b1) $display("FAIL resume_run_ce got %b exp 1", core_enable); else passed++;
        run_key = 1'b0;
        break_enable = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_priorities();
        logic lock_bad = 1'b0;
        // Halt request does not block HALTED->RUN, but RUN exits next edge.
        do_reset();
        halt_request = 1'b1;
        run_key = 1'b1;
        repeat (7) @(negedge clock);
        total++; if (state !== 3'd2) $display("FAIL halt_req_state got %0d exp 2", state); else passed++;
        total++; if (core_enable !== 1'b0) $display("FAIL halt_req_ce got %b exp 0", core_enable); else passed++;
        @(negedge clock);
        total++; if (state !== 3'd0) $display("FAIL halt_req_exit got %0d exp 0", state); else passed++;
        run_key = 1'b0;
        repeat (12) @(negedge clock);
        halt_request = 1'b0;

        // Lock during RUN.
        run_key = 1'b1;
        repeat (7) @(negedge clock);
        run_key = 1'b0;
        repeat (12) @(negedge clock);
        clock_lock = 1'b1;
        #1;
        total++; if (core_enable !== 1'b0) $display("FAIL lock_ce got %b exp 0", core_enable); else passed++;
        total++; if (state !== 3'd2) $display("FAIL lock_state_pre got %0d exp 2", state); else passed++;
        @(negedge clock);
        total++; if (state !== 3'd0) $display("FAIL lock_state got %0d exp 0", state); else passed++;
        step_key = 1'b1;
        run_key  = 1'b1;
        repeat (12) begin
            @(negedge clock);
            if (state !== 3'd0 || core_enable !== 1'b0) lock_bad = 1'b1;
        end
        total++; if (lock_bad !== 1'b0) $display("FAIL lock_ignores_keys got %b exp 0", lock_bad); else passed++;
        step_key = 1'b0;
        run_key  = 1'b0;
        repeat (12) @(negedge clock);
        clock_lock = 1'b0;
        @(negedge clock);

        // Simultaneous presses in HALTED: step wins.
        step_key = 1'b1;
        run_key  = 1'b1;
        repeat (7) @(negedge clock);
        total++; if (state !== 3'd1) $display("FAIL both_state got %0d exp 1", state); else passed++;
        @(negedge clock);
        total++; if (state !== 3'd0) $display("FAIL both_after got %0d exp 0", state); else passed++;
        step_key = 1'b0;
        run_key  = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        run_key = 1'b1;
        repeat (7) @(negedge clock);
        run_key = 1'b0;
        repeat (65535) @(negedge clock);
        total++; if (step_count !== 16'hFFFF) $display("FAIL wrap_pre got %h exp ffff", step_count); else passed++;
        @(negedge clock);
        total++; if (step_count !== 16'h0000) $display("FAIL wrap got %h exp 0000", step_count); else passed++;
        total++; if (state !== 3'd2) $display("FAIL wrap_state got %0d exp 2", state); else passed++;
        repeat (5) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        total++; if (state !== 3'd0) $display("FAIL async_state got %0d exp 0", state); else passed++;
        total++; if (core_enable !== 1'b0) $display("FAIL async_ce got %b exp 0", core_enable); else passed++;
        total++; if (running !== 1'b0) $display("FAIL async_running got %b exp 0", running); else passed++;
        total++; if (break_hit !== 1'b0) $display("FAIL async_break_hit got %b exp 0", break_hit); else passed++;
        total++; if (step_count !== 16'd0) $display("FAIL async_count got %0d exp 0", step_count); else passed++;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_bounce();
        test_run_stop();
        test_breakpoint();
        test_priorities();
        test_wrap_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
